// File: rtl/controle_asteroides.sv
// controle_asteroides: sequencing FSM that sweeps the asteroid slots once per iniciar pulse.
// Optional spawn support is compiled in when ASTE_SPAWN_EN is defined.
module controle_asteroides #(
    parameter int N_SLOTS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       spawn_aste,
    input  logic       loaded_aste,
    input  logic       destruido_aste,
    input  logic [1:0] opcode_aste,
    input  logic [3:0] aste_coor_x,
    input  logic [3:0] aste_coor_y,
    input  logic       colisao_aste_com_nave,
    input  logic       rco_contador_aste,
    output logic       conta_contador_aste,
    output logic       reset_contador_aste,
    output logic [1:0] select_mux_pos_aste,
    output logic       select_mux_coor_aste,
    output logic       select_soma_sub_aste,
    output logic       enable_mem_aste,
    output logic       enable_load_aste,
    output logic       new_load_aste,
    output logic       new_destruido_aste,
    output logic       enable_reg_nave,
    output logic       reset_reg_nave,
    output logic       colisao_nave,
    output logic       fim_sweep,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        INICIO   = 4'd1,
        LE       = 4'd2,
        AVALIA   = 4'd3,
        MOVE     = 4'd4,
        DESCARTA = 4'd5,
        COLIDE   = 4'd6,
        SPAWN    = 4'd7,
        PROXIMO  = 4'd8,
        FIM      = 4'd9
    } estado_t;

    estado_t estado_q, estado_d;
    logic    colisao_q, colisao_d;
    logic    borda;
    logic    spawn_ok;
    logic    unused_cfg;

    assign unused_cfg = ^N_SLOTS;

    // A step that would leave the 16x16 field discards the asteroid instead of wrapping.
    assign borda = (opcode_aste == 2'b00 && aste_coor_x == 4'd15) ||
                   (opcode_aste == 2'b01 && aste_coor_x == 4'd0)  ||
                   (opcode_aste == 2'b10 && aste_coor_y == 4'd15) ||
                   (opcode_aste == 2'b11 && aste_coor_y == 4'd0);

`ifdef ASTE_SPAWN_EN
    logic pend_q, pend_d, feito_q, feito_d;

    // feito limits service to one spawn per sweep even if a new request arrives mid-sweep.
    assign spawn_ok = pend_q && !feito_q;

    always_comb begin
        pend_d  = pend_q;
        feito_d = feito_q;
        if (estado_q == SPAWN) begin
            pend_d  = 1'b0;
            feito_d = 1'b1;
        end
        if (estado_q == INICIO) feito_d = 1'b0;
        if (spawn_aste) pend_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q  <= 1'b0;
            feito_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            feito_q <= feito_d;
        end
    end
`else
    logic unused_spawn;
    assign unused_spawn = spawn_aste;
    assign spawn_ok     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= IDLE;
            colisao_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            colisao_q <= colisao_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:     if (iniciar) estado_d = INICIO;
            INICIO:   estado_d = LE;
            LE:       estado_d = AVALIA;
            AVALIA: begin
                if (!loaded_aste)               estado_d = spawn_ok ? SPAWN : PROXIMO;
                else if (destruido_aste)        estado_d = PROXIMO;
                else if (colisao_aste_com_nave) estado_d = COLIDE;
                else if (borda)                 estado_d = DESCARTA;
                else                            estado_d = MOVE;
            end
            MOVE, DESCARTA, COLIDE, SPAWN: estado_d = PROXIMO;
            PROXIMO:  estado_d = rco_contador_aste ? FIM : LE;
            FIM:      estado_d = IDLE;
            default:  estado_d = IDLE;
        endcase
    end

    always_comb begin
        colisao_d = colisao_q;
        if (estado_q == INICIO) colisao_d = 1'b0;
        if (estado_q == COLIDE) colisao_d = 1'b1;
    end

    // Moore outputs; held at defaults while reset is asserted so no write slips out.
    always_comb begin
        conta_contador_aste  = 1'b0;
        reset_contador_aste  = 1'b0;
        select_mux_pos_aste  = 2'b11;
        select_mux_coor_aste = 1'b0;
        select_soma_sub_aste = 1'b0;
        enable_mem_aste      = 1'b0;
        enable_load_aste     = 1'b0;
        new_load_aste        = 1'b0;
        new_destruido_aste   = 1'b0;
        enable_reg_nave      = 1'b0;
        reset_reg_nave       = 1'b0;
        fim_sweep            = 1'b0;
        pronto               = 1'b0;
        if (reset) begin
            reset_reg_nave = 1'b1;
        end else begin
            case (estado_q)
                IDLE: pronto = 1'b1;
                INICIO: begin
                    reset_contador_aste = 1'b1;
                    enable_reg_nave     = 1'b1;
                end
                MOVE: begin
                    select_mux_coor_aste = opcode_aste[1];
                    select_soma_sub_aste = opcode_aste[0];
                    select_mux_pos_aste  = {1'b0, opcode_aste[1]};
                    enable_mem_aste      = 1'b1;
                end
                DESCARTA: enable_load_aste = 1'b1;
                COLIDE: begin
                    enable_load_aste   = 1'b1;
                    new_load_aste      = 1'b1;
                    new_destruido_aste = 1'b1;
                end
`ifdef ASTE_SPAWN_EN
                SPAWN: begin
                    select_mux_pos_aste = 2'b10;
                    enable_mem_aste     = 1'b1;
                    enable_load_aste    = 1'b1;
                    new_load_aste       = 1'b1;
                end
`endif
                PROXIMO: conta_contador_aste = 1'b1;
                FIM:     fim_sweep           = 1'b1;
                default: ;
            endcase
        end
    end

    assign colisao_nave = colisao_q;
    assign db_estado    = estado_q;

endmodule
